// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-port data memory controller with a fixed-latency
// request/response handshake.
//
// Memory is DEPTH 32-bit words, stored as four little-endian byte lanes.
// A request is accepted in IDLE. Stores commit at the accept edge. Loads
// sample the word at the accept edge. The response pulse comes LATENCY
// cycles after the accept edge. Misaligned, illegal-size or out-of-range
// requests leave memory untouched and respond with resp_err=1.
//
// Ports:
//   clk, reset            clock, async active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_write             1 = store, 0 = load
//   req_size              00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned          load zero-extends when 1, sign-extends when 0
//   address, write_data   byte address, right-aligned store data
//   resp_valid            one-cycle response pulse
//   data_out, resp_err    load result / error flag, zero unless resp_valid

// One byte lane of the memory array. Reset loads byte LANE of the word
// index, so the assembled word i reads back as i.
module data_mem_lane #(
    parameter int DEPTH = 64,
    parameter int LANE  = 0,
    parameter int IW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [IW-1:0] idx,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= 8'((i >> (8 * LANE)) & 255);
        end else if (we) begin
            mem[idx] <= wdata;
        end
    end

    // idx is only meaningful when the request is in range; an
    // out-of-range read is discarded by the error path.
    assign rdata = mem[idx];
endmodule

module data_mem_ctrl #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic        resp_valid,
    output logic [31:0] data_out,
    output logic        resp_err
);
    localparam int NUM_LANES = 4;
    localparam int IW = $clog2(DEPTH);
    localparam logic [2:0] CNT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // Request fields held from accept until the response.
    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  off;
        logic        err;
        logic [31:0] rdata;
    } req_t;

    logic [1:0] state;
    logic [2:0] cnt;
    req_t       req_q;

    logic                            accept;
    logic                            in_range;
    logic                            req_err;
    logic [NUM_LANES-1:0]            lane_we;
    logic [NUM_LANES-1:0][7:0]       lane_wd;
    logic [NUM_LANES-1:0][7:0]       rd_word;
    logic [31:0]                     shifted;
    logic [31:0]                     ld_data;

    assign accept   = (state == IDLE) && req_valid;
    assign in_range = ({2'b00, address[31:2]} < 32'(DEPTH));

    always_comb begin
        req_err = 1'b0;
        case (req_size)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = address[0];
            2'b10:   req_err = (address[1:0] != 2'b00);
            default: req_err = 1'b1;
        endcase
        if (!in_range)
            req_err = 1'b1;
    end

    // Store data is replicated across lanes so every enabled lane sees
    // the right bytes without a per-lane mux on the offset.
    always_comb begin
        lane_we = '0;
        lane_wd = write_data;
        case (req_size)
            2'b00: begin
                lane_wd = {4{write_data[7:0]}};
                lane_we[address[1:0]] = 1'b1;
            end
            2'b01: begin
                lane_wd = {2{write_data[15:0]}};
                lane_we[{address[1], 1'b0}] = 1'b1;
                lane_we[{address[1], 1'b1}] = 1'b1;
            end
            2'b10:   lane_we = '1;
            default: lane_we = '0;
        endcase
        if (!(accept && req_write && !req_err))
            lane_we = '0;
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        data_mem_lane #(
            .DEPTH (DEPTH),
            .LANE  (g),
            .IW    (IW)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .we    (lane_we[g]),
            .idx   (address[IW+1:2]),
            .wdata (lane_wd[g]),
            .rdata (rd_word[g])
        );
    end

    // IDLE -> (WAIT) -> RESP -> IDLE. WAIT spends LATENCY-1 cycles so the
    // RESP cycle ends exactly LATENCY edges after the accept edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            req_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_q.write <= req_write;
                        req_q.size  <= req_size;
                        req_q.uns   <= req_unsigned;
                        req_q.off   <= address[1:0];
                        req_q.err   <= req_err;
                        req_q.rdata <= rd_word;
                        if (LATENCY == 1) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 3'd0)
                        state <= RESP;
                    else
                        cnt <= cnt - 3'd1;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Load extraction: shift the addressed lane down, then extend.
    always_comb begin
        shifted = req_q.rdata >> {req_q.off, 3'b000};
        ld_data = '0;
        case (req_q.size)
            2'b00:   ld_data = {{24{~req_q.uns & shifted[7]}}, shifted[7:0]};
            2'b01:   ld_data = {{16{~req_q.uns & shifted[15]}}, shifted[15:0]};
            2'b10:   ld_data = shifted;
            default: ld_data = '0;
        endcase
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_err   = resp_valid && req_q.err;
    assign data_out   = (resp_valid && !req_q.write && !req_q.err) ? ld_data : 32'h0;
endmodule

// File: tb/tb_data_mem_ctrl.sv
`timescale 1ns/1ps
module tb_data_mem_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        v1, v4, wr, un;
    logic [1:0]  sz;
    logic [31:0] addr, wd;
    logic        rdy1, rv1, er1, rdy4, rv4, er4;
    logic [31:0] do1, do4;

    data_mem_ctrl #(.DEPTH(64), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rdy1),
        .req_write(wr), .req_size(sz), .req_unsigned(un), .address(addr),
        .write_data(wd), .resp_valid(rv1), .data_out(do1), .resp_err(er1));

    data_mem_ctrl #(.DEPTH(64), .LATENCY(4)) dut4 (
        .clk(clk), .reset(reset), .req_valid(v4), .req_ready(rdy4),
        .req_write(wr), .req_size(sz), .req_unsigned(un), .address(addr),
        .write_data(wd), .resp_valid(rv4), .data_out(do4), .resp_err(er4));

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          acc;
        string       name;
    } exp_t;

    typedef struct {
        logic        w;
        logic [1:0]  s;
        logic        u;
        logic [31:0] a;
        logic [31:0] d;
        logic        ee;
        logic [31:0] ed;
        string       name;
    } vec_t;

    exp_t q1[$];
    exp_t q4[$];
    vec_t tbl[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic mon(input exp_t e, input logic err, input logic [31:0] d, input int lat);
        chk({e.name, " err"}, 32'(err), 32'(e.err));
        chk({e.name, " data"}, d, e.data);
        chk({e.name, " latency"}, 32'(cyc - e.acc + 1), 32'(lat));
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: resp_valid with no outstanding request", name);
    endtask

    // Scoreboard: pop one expectation per response pulse; outputs must be
    // zero whenever no response is presented.
    always @(negedge clk) begin
        if (!reset) begin
            if (rv1) begin
                if (q1.size() == 0) unexpected("dut1 resp");
                else mon(q1.pop_front(), er1, do1, 1);
            end else begin
                chk("dut1 idle outputs", do1 | 32'(er1), 32'h0);
            end
            if (rv4) begin
                if (q4.size() == 0) unexpected("dut4 resp");
                else mon(q4.pop_front(), er4, do4, 4);
            end else begin
                chk("dut4 idle outputs", do4 | 32'(er4), 32'h0);
            end
        end
    end

    task automatic add(input logic w, input logic [1:0] s, input logic u, input logic [31:0] a,
                       input logic [31:0] d, input logic ee, input logic [31:0] ed, input string name);
        vec_t v;
        v.w = w; v.s = s; v.u = u; v.a = a; v.d = d; v.ee = ee; v.ed = ed; v.name = name;
        tbl.push_back(v);
    endtask

    // Called at a negedge; returns at a negedge once the response is scored.
    task automatic req(input bit sel, input logic w, input logic [1:0] s, input logic u,
                       input logic [31:0] a, input logic [31:0] d, input logic ee,
                       input logic [31:0] ed, input string name);
        exp_t e;
        int n;
        wr = w; sz = s; un = u; addr = a; wd = d;
        if (sel) v4 = 1'b1; else v1 = 1'b1;
        n = 0;
        while (!(sel ? rdy4 : rdy1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, " accepted"}, 32'(n < 20), 32'h1);
        e.err = ee; e.data = ed; e.acc = cyc + 1; e.name = name;
        if (sel) q4.push_back(e); else q1.push_back(e);
        @(posedge clk);
        #1;
        v1 = 1'b0;
        v4 = 1'b0;
        n = 0;
        while (((sel ? q4.size() : q1.size()) != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, " responded"}, 32'(n < 20), 32'h1);
        if (sel) q4.delete(); else q1.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int seen, low, acc_cnt;
        exp_t e;
        v1 = 0; v4 = 0; wr = 0; sz = 0; un = 0; addr = 0; wd = 0;

        //      w  size  u  addr          wdata          err expected
        add(0, 2'b10, 0, 32'h0C,  32'h0,          0, 32'h0000_0003, "word ld 0x0C");
        add(1, 2'b10, 0, 32'h10,  32'h8081_F0FF,  0, 32'h0,         "word st 0x10");
        add(0, 2'b00, 0, 32'h10,  32'h0,          0, 32'hFFFF_FFFF, "byte ld s 0x10");
        add(0, 2'b00, 1, 32'h11,  32'h0,          0, 32'h0000_00F0, "byte ld u 0x11");
        add(0, 2'b01, 0, 32'h12,  32'h0,          0, 32'hFFFF_8081, "half ld s 0x12");
        add(0, 2'b00, 1, 32'h13,  32'h0,          0, 32'h0000_0080, "byte ld u 0x13");
        add(1, 2'b01, 0, 32'h06,  32'h0000_ABCD,  0, 32'h0,         "half st 0x06");
        add(0, 2'b10, 0, 32'h04,  32'h0,          0, 32'hABCD_0001, "word ld 0x04");
        add(0, 2'b10, 0, 32'h02,  32'h0,          1, 32'h0,         "word ld misaligned");
        add(0, 2'b10, 0, 32'h100, 32'h0,          1, 32'h0,         "word ld out of range");
        add(1, 2'b10, 0, 32'h100, 32'h0000_DEAD,  1, 32'h0,         "word st out of range");
        add(0, 2'b10, 0, 32'h00,  32'h0,          0, 32'h0000_0000, "word ld 0x00 intact");
        add(0, 2'b10, 0, 32'hFC,  32'h0,          0, 32'h0000_003F, "word ld last");
        add(0, 2'b11, 0, 32'h08,  32'h0,          1, 32'h0,         "illegal size");
        add(1, 2'b00, 0, 32'h09,  32'h1234_5699,  0, 32'h0,         "byte st 0x09");
        add(0, 2'b10, 0, 32'h08,  32'h0,          0, 32'h0000_9902, "word ld 0x08");
        add(0, 2'b00, 0, 32'h09,  32'h0,          0, 32'hFFFF_FF99, "byte ld s 0x09");
        add(0, 2'b01, 1, 32'h08,  32'h0,          0, 32'h0000_9902, "half ld u 0x08");
        add(0, 2'b01, 0, 32'h0B,  32'h0,          1, 32'h0,         "half ld misaligned");
        add(1, 2'b01, 0, 32'h01,  32'h0000_FFFF,  1, 32'h0,         "half st misaligned");
        add(0, 2'b10, 0, 32'h00,  32'h0,          0, 32'h0000_0000, "word ld 0x00 after bad st");

        #1;
        chk("reset ready1", 32'(rdy1), 32'h1);
        chk("reset valid1", 32'(rv1), 32'h0);
        chk("reset data1", do1, 32'h0);
        chk("reset ready4", 32'(rdy4), 32'h1);
        chk("reset err4", 32'(er4), 32'h0);

        repeat (2) @(negedge clk);
        reset = 1'b0;

        // First request is driven right after reset deasserts, so it must be
        // accepted on the very next rising edge.
        foreach (tbl[i])
            req(0, tbl[i].w, tbl[i].s, tbl[i].u, tbl[i].a, tbl[i].d, tbl[i].ee, tbl[i].ed, tbl[i].name);

        // LATENCY=4 with req_valid held high: ready low 4 cycles per accept.
        wr = 0; sz = 2'b10; un = 0; addr = 32'h0C; wd = 0;
        v4 = 1'b1;
        seen = 0; low = 0; acc_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (rdy4) begin
                if (seen != 0) chk("lat4 ready low cycles", 32'(low), 32'd4);
                e.err = 0; e.data = 32'h3; e.acc = cyc + 1; e.name = "lat4 streaming load";
                q4.push_back(e);
                seen = 1; low = 0; acc_cnt++;
            end else begin
                low++;
            end
            @(negedge clk);
        end
        v4 = 1'b0;
        chk("lat4 accept count", 32'(acc_cnt), 32'd3);
        for (int n = 0; n < 20 && q4.size() != 0; n++) @(negedge clk);
        chk("lat4 stream drained", 32'(q4.size()), 32'd0);
        q4.delete();

        // Reset during WAIT drops the store and restores the init image.
        wr = 1; sz = 2'b10; un = 0; addr = 32'h00; wd = 32'h55;
        v4 = 1'b1;
        chk("rst-mid ready before accept", 32'(rdy4), 32'h1);
        @(posedge clk);
        #1 v4 = 1'b0;
        @(negedge clk);
        chk("rst-mid in WAIT", 32'(rdy4), 32'h0);
        reset = 1'b1;
        #1;
        chk("rst-mid ready", 32'(rdy4), 32'h1);
        chk("rst-mid resp_valid", 32'(rv4), 32'h0);
        chk("rst-mid data_out", do4, 32'h0);
        chk("rst-mid resp_err", 32'(er4), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        req(1, 0, 2'b10, 0, 32'h00, 32'h0, 0, 32'h0000_0000, "post-reset ld 0x00");
        req(0, 0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h0000_0004, "post-reset ld 0x10");
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 64: number of 32-bit words; legal range 4..1024.
REQ-002 SHALL have parameter LATENCY, default 1: cycles from accept edge to resp_valid; legal range 1..8.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1: request present.
REQ-006 SHALL have port req_ready, output, 1: block can accept a request.
REQ-007 SHALL have port req_write, input, 1: 1 = store, 0 = load.
REQ-008 SHALL have port req_size, input, 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-009 SHALL have port req_unsigned, input, 1: load zero-extends when 1 and sign-extends when 0.
REQ-010 SHALL have port address, input, 32: byte address.
REQ-011 SHALL have port write_data, input, 32: store data, right-aligned.
REQ-012 SHALL have port resp_valid, output, 1: one-cycle response pulse.
REQ-013 SHALL have port data_out, output, 32: load result, valid only with resp_valid.
REQ-014 SHALL have port resp_err, output, 1: request rejected, valid only with resp_valid.

Function
REQ-015 SHALL implement an FSM with states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 SHALL accept a request on a rising edge with req_valid=1 in IDLE, capturing all request fields.
REQ-017 SHALL, on accept, move to RESP if LATENCY=1; otherwise it SHALL move to WAIT and load a counter with LATENCY-2.
REQ-018 SHALL, in WAIT, decrement the counter each cycle and move to RESP on the cycle after the counter reads 0.
REQ-019 SHALL hold RESP for exactly one cycle with resp_valid=1, then return to IDLE; sustained throughput SHALL be 1 request per LATENCY+1 cycles.
REQ-020 SHALL compute the word index as address[31:2], and SHALL place byte lanes little-endian (address[1:0] selects the lane).
REQ-021 SHALL flag an error when: req_size=11; or a half access has address[0]=1; or a word access has address[1:0]!=00; or the word index is >= DEPTH.
REQ-022 SHALL, for a store without error, update only the addressed lanes at the accept edge: byte from write_data[7:0], half from write_data[15:0], word from all 32 bits.
REQ-023 SHALL, for a load without error, read memory at the accept edge and, in RESP, drive the addressed byte/half/word on data_out, extended per req_unsigned.
REQ-024 SHALL, for an erroneous request, leave memory unchanged, drive resp_err=1 with data_out=0, and still complete the full LATENCY handshake.
REQ-025 SHALL drive data_out=0 for every store response.
REQ-026 SHALL drive data_out=0 and resp_err=0 whenever resp_valid=0.
REQ-027 SHALL ignore req_valid outside IDLE; requests SHALL NOT be queued.

Reset
REQ-028 SHALL, on reset assertion, immediately force state to IDLE, req_ready=1, resp_valid=0, resp_err=0, data_out=0 and the counter to 0.
REQ-029 SHALL, on reset, initialise memory word i to value i for i = 0..DEPTH-1.
REQ-030 SHALL drop an in-flight request when reset asserts mid-operation: no response is produced, and a store already committed at its accept edge is overwritten by the reset initialisation.
REQ-031 SHALL accept the first request on the first rising edge after reset deasserts.

Verification
REQ-032 SHALL cover: after reset, LATENCY=1, word load at address 0x0C -> resp_valid exactly 1 cycle later, data_out=0x00000003, resp_err=0.
REQ-033 SHALL cover: word store 0x8081_F0FF to 0x10, then byte load 0x10 signed -> 0xFFFFFFFF; byte load 0x11 unsigned -> 0x000000F0; half load 0x12 signed -> 0xFFFF8081.
REQ-034 SHALL cover: half store 0xABCD to 0x06, then word load 0x04 -> 0xABCD0001.
REQ-035 SHALL cover: word load at 0x02, and word load at DEPTH*4 -> resp_err=1, data_out=0, with memory at both addresses unchanged.
REQ-036 SHALL cover: LATENCY=4, req_valid held high continuously -> req_ready low for 4 cycles after each accept, resp_valid at accept+4, and no second accept before RESP completes.
REQ-037 SHALL cover: reset asserted during WAIT after a store of 0x55 to 0x00 -> no resp_valid, and a subsequent load of 0x00 returns 0x00000000.
